bq_ctrl: RTL and testbench

Branch-queue controller. Allocates a branch-queue slot (`bqid`) to every control-flow instruction pushed by decode and stores its PC and prediction. It compares each branch-unit resolution against the stored prediction and emits a registered mispredict request toward the squash logic. Slots are freed in order at commit, and on squash every slot younger than the squash point is reclaimed. It sits between decode (push side), the branch unit (resolve side) and commit.

---
 rtl/bq_ctrl_pkg.sv | 33 +++
 rtl/bq_ctrl_if.sv | 29 ++
 rtl/bq_age_cmp.sv | 15 +
 rtl/bq_ctrl.sv | 126 ++++++++++++
 tb/tb_bq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bq_ctrl_pkg.sv
// Shared types for the branch-queue controller: slot state, slot contents,
// and the PC / instruction-id / branch-prediction types used on its ports.
package bq_ctrl_pkg;

  localparam int NR_BQ_ENTRIES = 8;
  localparam int BQ_ID_W       = $clog2(NR_BQ_ENTRIES);
  localparam int PC_W          = 32;
  localparam int ID_W          = 4;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [ID_W-1:0]    id_t;
  typedef logic [BQ_ID_W-1:0] bqid_t;

  // Prediction made at fetch: direction and predicted next PC.
  typedef struct packed {
    logic taken;
    pc_t  pcnext;
  } bp_t;

  typedef enum logic [1:0] {
    BQ_FREE     = 2'd0,
    BQ_PENDING  = 2'd1,
    BQ_RESOLVED = 2'd2
  } bq_state_e;

  typedef struct packed {
    bq_state_e state;
    pc_t       pc;
    id_t       id;
    bp_t       bp;
  } bq_entry_t;

endpackage

// File: rtl/bq_ctrl_if.sv
// Decode push and pipeline squash bundles.
// Handshake: push is accepted at the rising edge when valid is high, full_o
// is low and no squash is in progress; bqid is the slot that would be
// allocated and is valid combinationally in the same cycle. Squash has no
// back-pressure: valid for one cycle means it takes effect at the next edge.
interface bq_push_if
  import bq_ctrl_pkg::*;
#(
  parameter int BQID_W = BQ_ID_W
) ();
  logic              valid;
  pc_t               pc;
  id_t               id;
  bp_t               bp;
  logic [BQID_W-1:0] bqid;

  modport master (output valid, output pc, output id, output bp, input  bqid);
  modport slave  (input  valid, input  pc, input  id, input  bp, output bqid);
endinterface

interface squash_if
  import bq_ctrl_pkg::*;
();
  logic valid;
  id_t  id;

  modport master (output valid, output id);
  modport slave  (input  valid, input  id);
endinterface

// File: rtl/bq_age_cmp.sv
// Younger-than comparator on wrapping instruction ids: id is younger than
// pt_id when the signed difference (id - pt_id) is strictly positive.
module bq_age_cmp
  import bq_ctrl_pkg::*;
(
  input  id_t  id,
  input  id_t  pt_id,
  output logic younger
);
  logic signed [ID_W-1:0] diff;

  // Modular difference reinterpreted as signed handles id wrap-around.
  assign diff    = id - pt_id;
  assign younger = (diff > 0);
endmodule

// File: rtl/bq_ctrl.sv
// Branch-queue controller: allocates slots to branches in program order,
// checks resolutions against the stored prediction, raises a registered
// mispredict request, retires in order and rolls back younger slots on squash.
module bq_ctrl
  import bq_ctrl_pkg::*;
#(
  parameter  int NR_ENTRIES = NR_BQ_ENTRIES,
  localparam int BQID_W     = $clog2(NR_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  bq_push_if.slave          bq_push_io,
  squash_if.slave           squash_io,
  output logic              full_o,
  output logic              empty_o,
  output logic [BQID_W:0]   count_o,
  input  logic              res_valid_i,
  input  logic [BQID_W-1:0] res_bqid_i,
  input  logic              res_taken_i,
  input  pc_t               res_target_i,
  input  logic              commit_valid_i,
  output logic              mp_valid_o,
  output id_t               mp_id_o,
  output pc_t               mp_pc_o,
  output logic              err_o
);
  localparam logic [BQID_W:0] FULL_CNT = (BQID_W+1)'(NR_ENTRIES);

  bq_entry_t         entries_q [NR_ENTRIES];
  logic [BQID_W-1:0] head_q, tail_q, head_nxt, sq_tail;
  logic [BQID_W:0]   count_q, count_nxt;
  logic              mp_valid_q, err_q;
  id_t               mp_id_q;
  pc_t               mp_pc_q;

  logic [NR_ENTRIES-1:0] younger;
  logic                  mp_younger, sq_hit;
  logic                  push_ok, commit_ok, res_live, mispredict, mp_set, err_set;
  bq_entry_t             head_ent, res_ent;

  // Per-slot age comparison against the squash point.
  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_age
    bq_age_cmp u_age (.id(entries_q[g].id), .pt_id(squash_io.id), .younger(younger[g]));
  end

  // Same comparison for the in-flight mispredict so a squash can cancel it.
  bq_age_cmp u_mp_age (.id(mp_id_q), .pt_id(squash_io.id), .younger(mp_younger));

  // Event qualification, mispredict detection and error sources.
  always_comb begin
    full_o     = (count_q == FULL_CNT);
    empty_o    = (count_q == '0);
    head_ent   = entries_q[head_q];
    res_ent    = entries_q[res_bqid_i];
    push_ok    = bq_push_io.valid && !full_o && !squash_io.valid;
    commit_ok  = commit_valid_i && !empty_o && (head_ent.state == BQ_RESOLVED);
    res_live   = res_valid_i && (res_ent.state != BQ_FREE);
    mispredict = (res_taken_i != res_ent.bp.taken) ||
                 (res_taken_i && (res_target_i != res_ent.bp.pcnext));
    mp_set     = res_live && mispredict && !(squash_io.valid && younger[res_bqid_i]);
    err_set    = (bq_push_io.valid && full_o && !squash_io.valid) ||
                 (commit_valid_i && !commit_ok) ||
                 (res_valid_i && (res_ent.state == BQ_FREE));
    head_nxt   = head_q + BQID_W'(commit_ok);
  end

  // Find the oldest allocated slot younger than the squash point; the tail rolls back there.
  always_comb begin
    sq_hit  = 1'b0;
    sq_tail = tail_q;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      logic [BQID_W-1:0] idx;
      idx = head_q + BQID_W'(i);
      if (!sq_hit && ((BQID_W+1)'(i) < count_q) &&
          (entries_q[idx].state != BQ_FREE) && younger[idx]) begin
        sq_hit  = 1'b1;
        sq_tail = idx;
      end
    end
  end

  // Occupancy: recomputed from the pointers after a rollback, else incremental.
  always_comb begin
    if (squash_io.valid && sq_hit) count_nxt = {1'b0, sq_tail - head_nxt};
    else count_nxt = count_q + (BQID_W+1)'(push_ok) - (BQID_W+1)'(commit_ok);
  end

  // Queue state; later writes win, giving squash > commit > resolve > push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mp_valid_q <= 1'b0;
      mp_id_q    <= '0;
      mp_pc_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NR_ENTRIES; i++) entries_q[i] <= '{state: BQ_FREE, default: '0};
    end else begin
      head_q     <= head_nxt;
      tail_q     <= squash_io.valid ? sq_tail : tail_q + BQID_W'(push_ok);
      count_q    <= count_nxt;
      err_q      <= err_q | err_set;
      mp_valid_q <= mp_set;
      if (mp_set) begin
        mp_id_q <= res_ent.id;
        mp_pc_q <= res_taken_i ? res_target_i : res_ent.pc + 32'd4;
      end
      if (push_ok)
        entries_q[tail_q] <= '{state: BQ_PENDING, pc: bq_push_io.pc,
                               id: bq_push_io.id, bp: bq_push_io.bp};
      if (res_live) entries_q[res_bqid_i].state <= BQ_RESOLVED;
      if (commit_ok) entries_q[head_q].state <= BQ_FREE;
      if (squash_io.valid)
        for (int i = 0; i < NR_ENTRIES; i++)
          if (younger[i]) entries_q[i].state <= BQ_FREE;
    end
  end

  assign bq_push_io.bqid = tail_q;
  assign count_o         = count_q;
  assign mp_valid_o      = mp_valid_q && !(squash_io.valid && mp_younger);
  assign mp_id_o         = mp_id_q;
  assign mp_pc_o         = mp_pc_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_bq_ctrl.sv
// Directed bench for bq_ctrl: fill/overflow, correct and wrong predictions,
// squash rollback, id wrap-around and same-cycle collisions.
module tb_bq_ctrl;
  import bq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       full_o, empty_o, mp_valid_o, err_o;
  logic [3:0] count_o;
  logic       res_valid, res_taken, commit_valid;
  logic [2:0] res_bqid;
  pc_t        res_target, mp_pc_o;
  id_t        mp_id_o;
  int         total = 0;
  int         bad   = 0;

  bq_push_if #(.BQID_W(3)) push_if ();
  squash_if                sq_if ();

  bq_ctrl #(.NR_ENTRIES(8)) dut (
    .clk(clk), .rst(rst), .bq_push_io(push_if), .squash_io(sq_if),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .res_valid_i(res_valid), .res_bqid_i(res_bqid), .res_taken_i(res_taken),
    .res_target_i(res_target), .commit_valid_i(commit_valid),
    .mp_valid_o(mp_valid_o), .mp_id_o(mp_id_o), .mp_pc_o(mp_pc_o), .err_o(err_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    push_if.valid = 1'b0; push_if.pc = '0; push_if.id = '0; push_if.bp = '0;
    sq_if.valid = 1'b0; sq_if.id = '0;
    res_valid = 1'b0; res_bqid = '0; res_taken = 1'b0; res_target = '0;
    commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] pc,
                      input logic tk, input logic [31:0] nxt);
    push_if.valid = 1'b1; push_if.id = id; push_if.pc = pc;
    push_if.bp = '{taken: tk, pcnext: nxt};
    tick();
    push_if.valid = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] slot, input logic tk, input logic [31:0] tgt);
    res_valid = 1'b1; res_bqid = slot; res_taken = tk; res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic commit();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_full",   32'(full_o),       0);
    check("rst_empty",  32'(empty_o),      1);
    check("rst_count",  32'(count_o),      0);
    check("rst_mp",     32'(mp_valid_o),   0);
    check("rst_mp_id",  32'(mp_id_o),      0);
    check("rst_mp_pc",  mp_pc_o,           0);
    check("rst_err",    32'(err_o),        0);
    check("rst_bqid",   32'(push_if.bqid), 0);
    rst = 1'b0;

    // Fill 8 slots, then overflow.
    for (int i = 0; i < 8; i++) begin
      check("fill_bqid", 32'(push_if.bqid), 32'(i));
      push(4'(i), 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    end
    check("fill_full",  32'(full_o),  1);
    check("fill_count", 32'(count_o), 8);
    check("fill_err0",  32'(err_o),   0);
    push(4'd8, 32'h2000, 1'b0, 32'h0);
    check("ovf_err",   32'(err_o),        1);
    check("ovf_count", 32'(count_o),      8);
    check("ovf_bqid",  32'(push_if.bqid), 0);

    // Asynchronous reset while the queue is full and err is set.
    #2 rst = 1'b1;
    #1;
    check("arst_full",  32'(full_o),  0);
    check("arst_empty", 32'(empty_o), 1);
    check("arst_count", 32'(count_o), 0);
    check("arst_err",   32'(err_o),   0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Correct taken prediction, then commit.
    push(4'd0, 32'h100, 1'b1, 32'h140);
    resolve(3'd0, 1'b1, 32'h140);
    check("ok_mp", 32'(mp_valid_o), 0);
    commit();
    check("ok_empty", 32'(empty_o), 1);
    check("ok_err",   32'(err_o),   0);

    // Predicted taken, actually not taken.
    check("nt_bqid", 32'(push_if.bqid), 1);
    push(4'd1, 32'h200, 1'b1, 32'h300);
    resolve(3'd1, 1'b0, 32'h0);
    check("nt_mp",    32'(mp_valid_o), 1);
    check("nt_mp_pc", mp_pc_o,         32'h204);
    check("nt_mp_id", 32'(mp_id_o),    1);
    tick();
    check("nt_mp_pulse", 32'(mp_valid_o), 0);
    commit();
    check("nt_empty", 32'(empty_o), 1);

    // Squash rollback.
    do_reset();
    push(4'd3, 32'h300, 1'b0, 32'h0);
    push(4'd4, 32'h304, 1'b0, 32'h0);
    push(4'd5, 32'h308, 1'b0, 32'h0);
    push(4'd6, 32'h30c, 1'b0, 32'h0);
    sq_if.valid = 1'b1; sq_if.id = 4'd4;
    push_if.valid = 1'b1; push_if.id = 4'd9;
    tick();
    clear_in();
    check("sq_count", 32'(count_o),      2);
    check("sq_bqid",  32'(push_if.bqid), 2);
    check("sq_err",   32'(err_o),        0);
    push(4'd5, 32'h308, 1'b0, 32'h0);
    check("sq_repush_count", 32'(count_o), 3);

    // Resolve of a slot freed by the same-cycle squash.
    push(4'd6, 32'h30c, 1'b0, 32'h0);
    res_valid = 1'b1; res_bqid = 3'd3; res_taken = 1'b1; res_target = 32'h600;
    sq_if.valid = 1'b1; sq_if.id = 4'd4;
    tick();
    clear_in();
    check("col_mp",    32'(mp_valid_o),   0);
    check("col_count", 32'(count_o),      2);
    check("col_bqid",  32'(push_if.bqid), 2);
    // Resolve of a surviving slot alongside a squash still mispredicts.
    res_valid = 1'b1; res_bqid = 3'd1; res_taken = 1'b1; res_target = 32'h500;
    sq_if.valid = 1'b1; sq_if.id = 4'd4;
    tick();
    clear_in();
    check("keep_mp",    32'(mp_valid_o), 1);
    check("keep_mp_id", 32'(mp_id_o),    4);
    check("keep_mp_pc", mp_pc_o,         32'h500);
    check("keep_err",   32'(err_o),      0);
    // A squash older than the pending mispredict cancels it.
    resolve(3'd1, 1'b1, 32'h500);
    sq_if.valid = 1'b1; sq_if.id = 4'd3;
    #1;
    check("mpclr_mp", 32'(mp_valid_o), 0);
    tick();
    clear_in();
    check("mpclr_count", 32'(count_o), 1);

    // Commit plus push at full.
    do_reset();
    for (int i = 0; i < 8; i++) push(4'(i), 32'h400 + 32'(4 * i), 1'b0, 32'h0);
    resolve(3'd0, 1'b0, 32'h0);
    check("cp_res_mp", 32'(mp_valid_o), 0);
    commit_valid = 1'b1;
    push_if.valid = 1'b1; push_if.id = 4'd8;
    tick();
    clear_in();
    check("cp_count", 32'(count_o),      7);
    check("cp_err",   32'(err_o),        1);
    check("cp_bqid",  32'(push_if.bqid), 0);

    // Wrap-around of bqid and id.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      check("wrap_bqid", 32'(push_if.bqid), 32'(k % 8));
      push(4'((10 + k) % 16), 32'h800 + 32'(4 * k), 1'b0, 32'h0);
      resolve(3'(k % 8), 1'b0, 32'h0);
      commit();
    end
    check("wrap_empty", 32'(empty_o), 1);
    check("wrap_err",   32'(err_o),   0);
    push(4'd14, 32'h900, 1'b0, 32'h0);
    push(4'd15, 32'h904, 1'b0, 32'h0);
    push(4'd0,  32'h908, 1'b0, 32'h0);
    push(4'd1,  32'h90c, 1'b0, 32'h0);
    check("wrap_count4", 32'(count_o), 4);
    sq_if.valid = 1'b1; sq_if.id = 4'd15;
    tick();
    clear_in();
    check("wsq_count", 32'(count_o),      2);
    check("wsq_bqid",  32'(push_if.bqid), 6);
    push(4'd0, 32'h908, 1'b0, 32'h0);
    check("wsq_repush", 32'(count_o), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
